// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab3 ALU operand loader.
package lab3_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ldr_state_t;

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_CLR = 2'b11;

endpackage

// File: rtl/key_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle press pulse on an accepted release-to-pressed transition.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          lvl_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          accept_c;

    // Synchronized level has differed from the accepted one long enough.
    assign accept_c = (sync2_q != lvl_q) && (cnt_q == CW'(DEBOUNCE_CYCLES));

    // Synchronize, qualify the level and generate the press pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            lvl_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            press_q <= accept_c && lvl_q;
            if (sync2_q == lvl_q) begin
                cnt_q <= '0;
            end else if (accept_c) begin
                lvl_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Builds ALU operands a nibble at a time from switches and issues them
// downstream over a valid/ready handshake on a debounced run press.
module alu_operand_loader
    import lab3_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned WIDTH           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_n,
    input  logic             run_n,
    input  logic [3:0]       sw_nib,
    input  logic [2:0]       sw_op,
    input  logic [1:0]       sw_sel,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [2:0]       op_ctrl,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [2:0]       cnt_a,
    output logic [2:0]       cnt_b,
    output logic             err
);

    localparam logic [2:0] CNT_MAX = 3'(WIDTH / 4);

    logic             enter_p;
    logic             run_p;
    ldr_state_t       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [2:0]       op_ctrl_q, op_ctrl_d;
    logic             op_valid_q, op_valid_d;
    logic [2:0]       cnt_a_q, cnt_a_d;
    logic [2:0]       cnt_b_q, cnt_b_d;
    logic             err_q, err_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk   (clk),
        .reset (reset),
        .key_n (enter_n),
        .press (enter_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk   (clk),
        .reset (reset),
        .key_n (run_n),
        .press (run_p)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: issue only with both operands non-empty; leave on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!enter_p && run_p && (cnt_a_q != 3'd0) && (cnt_b_q != 3'd0)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; enter takes priority over run in the same cycle.
    always_comb begin
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_ctrl_d  = op_ctrl_q;
        op_valid_d = op_valid_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (enter_p) begin
                    case (sw_sel)
                        SEL_A: begin
                            op_a_d  = {op_a_q[WIDTH-5:0], sw_nib};
                            cnt_a_d = (cnt_a_q == CNT_MAX) ? CNT_MAX : cnt_a_q + 3'd1;
                            err_d   = 1'b0;
                        end
                        SEL_B: begin
                            op_b_d  = {op_b_q[WIDTH-5:0], sw_nib};
                            cnt_b_d = (cnt_b_q == CNT_MAX) ? CNT_MAX : cnt_b_q + 3'd1;
                            err_d   = 1'b0;
                        end
                        SEL_CLR: begin
                            op_a_d  = '0;
                            op_b_d  = '0;
                            cnt_a_d = 3'd0;
                            cnt_b_d = 3'd0;
                            err_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end else if (run_p) begin
                    if ((cnt_a_q != 3'd0) && (cnt_b_q != 3'd0)) begin
                        op_ctrl_d  = sw_op;
                        op_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                end
            end
            default: op_valid_d = 1'b0;
        endcase
    end

    // Operand, control and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_ctrl_q  <= 3'd0;
            op_valid_q <= 1'b0;
            cnt_a_q    <= 3'd0;
            cnt_b_q    <= 3'd0;
            err_q      <= 1'b0;
        end else begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_ctrl_q  <= op_ctrl_d;
            op_valid_q <= op_valid_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            err_q      <= err_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_ctrl  = op_ctrl_q;
    assign op_valid = op_valid_q;
    assign cnt_a    = cnt_a_q;
    assign cnt_b    = cnt_b_q;
    assign err      = err_q;

endmodule
